// File: rtl/mc_arb_pkg.sv
// Shared encodings and helpers for the MiniComputer data-memory arbiter.
package mc_arb_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_CLI = 1'b1;

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_aligned(input logic [1:0] mode, input logic [1:0] addr_lo);
        logic ok;
        case (mode)
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_rr_pick2.sv
// Two-way round-robin picker: on a tie, grants the requester that did not win last.
module mc_rr_pick2
    import mc_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic cli_req,
    input  logic last_gnt,
    output logic gnt_c,
    output logic any_c
);

    always_comb begin
        any_c = cpu_req | cli_req;
        gnt_c = GNT_CPU;
        if (cpu_req && cli_req) begin
            gnt_c = (last_gnt == GNT_CPU) ? GNT_CLI : GNT_CPU;
        end else if (cli_req) begin
            gnt_c = GNT_CLI;
        end
    end

endmodule

// File: rtl/mc_dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU LSU and the client debug port.
// Define MC_ARB_STATS_EN to add saturating grant/error counters.
module mc_dmem_arbiter
    import mc_arb_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned TO_CYC = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          CpuReq,
    input  logic          CpuWe,
    input  logic [1:0]    CpuMode,
    input  logic [AW-1:0] CpuAddr,
    input  logic [DW-1:0] CpuWData,
    output logic          CpuDone,
    output logic [DW-1:0] CpuRData,
    input  logic [AW-1:0] ClientMemAddr,
    input  logic [DW-1:0] ClientMemWrite,
    input  logic [1:0]    CWDM,
    input  logic [1:0]    CRDM,
    output logic [DW-1:0] ClientMemRead,
    output logic          CReady,
    output logic          Err,
    output logic          MemEn,
    output logic          MemWe,
    output logic [1:0]    MemMode,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    input  logic          MemAck
`ifdef MC_ARB_STATS_EN
    ,
    output logic [15:0]   CpuGntCnt,
    output logic [15:0]   CliGntCnt,
    output logic [15:0]   ErrCnt
`endif
);

    localparam int unsigned    TW      = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TO_CYC - 1);

    function automatic logic [DW-1:0] zext(input logic [1:0] mode, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        case (mode)
            SZ_BYTE: r = DW'(d[7:0]);
            SZ_HALF: r = DW'(d[15:0]);
            default: r = d;
        endcase
        return r;
    endfunction

    logic [1:0]    state_q, nxt_state;
    logic          gnt_q, nxt_gnt;
    logic          last_gnt_q, nxt_last;
    logic [TW-1:0] timer_q, nxt_timer;

    logic          nxt_cpu_done, nxt_cready, nxt_err;
    logic [DW-1:0] nxt_cpu_rdata, nxt_cli_rdata;
    logic          nxt_mem_en, nxt_mem_we;
    logic [1:0]    nxt_mem_mode;
    logic [AW-1:0] nxt_mem_addr;
    logic [DW-1:0] nxt_mem_wdata;
    logic          fin, fin_err;
    logic [DW-1:0] fin_data;

    // Client write wins over a simultaneous client read.
    logic          cpu_req_c, cli_req_c, cli_we_c;
    logic [1:0]    cli_mode_c;
    logic          pick_gnt_c, pick_any_c;
    logic          sel_we_c;
    logic [1:0]    sel_mode_c;
    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] sel_data_c;

    assign cpu_req_c  = CpuReq & (CpuMode != SZ_NONE);
    assign cli_we_c   = (CWDM != SZ_NONE);
    assign cli_req_c  = cli_we_c | (CRDM != SZ_NONE);
    assign cli_mode_c = cli_we_c ? CWDM : CRDM;

    mc_rr_pick2 u_pick (
        .cpu_req  (cpu_req_c),
        .cli_req  (cli_req_c),
        .last_gnt (last_gnt_q),
        .gnt_c    (pick_gnt_c),
        .any_c    (pick_any_c)
    );

    assign sel_we_c   = (pick_gnt_c == GNT_CPU) ? CpuWe    : cli_we_c;
    assign sel_mode_c = (pick_gnt_c == GNT_CPU) ? CpuMode  : cli_mode_c;
    assign sel_addr_c = (pick_gnt_c == GNT_CPU) ? CpuAddr  : ClientMemAddr;
    assign sel_data_c = (pick_gnt_c == GNT_CPU) ? CpuWData : ClientMemWrite;

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        nxt_state     = state_q;
        nxt_gnt       = gnt_q;
        nxt_last      = last_gnt_q;
        nxt_timer     = timer_q;
        nxt_mem_en    = 1'b0;
        nxt_mem_we    = MemWe;
        nxt_mem_mode  = MemMode;
        nxt_mem_addr  = MemAddr;
        nxt_mem_wdata = MemWData;
        nxt_cpu_done  = 1'b0;
        nxt_cready    = 1'b0;
        nxt_err       = 1'b0;
        nxt_cpu_rdata = CpuRData;
        nxt_cli_rdata = ClientMemRead;
        fin           = 1'b0;
        fin_err       = 1'b0;
        fin_data      = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any_c) begin
                    nxt_gnt   = pick_gnt_c;
                    nxt_timer = '0;
                    if (is_aligned(sel_mode_c, sel_addr_c[1:0])) begin
                        nxt_state     = ST_ISSUE;
                        nxt_mem_en    = 1'b1;
                        nxt_mem_we    = sel_we_c;
                        nxt_mem_mode  = sel_mode_c;
                        nxt_mem_addr  = sel_addr_c;
                        nxt_mem_wdata = sel_data_c;
                    end else begin
                        nxt_state = ST_DONE;
                        fin       = 1'b1;
                        fin_err   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                nxt_state = ST_WAIT;
                nxt_timer = timer_q + TW'(1);
            end
            ST_WAIT: begin
                if (MemAck) begin
                    nxt_state = ST_DONE;
                    fin       = 1'b1;
                    fin_data  = zext(MemMode, MemRData);
                end else if (timer_q >= TO_LAST) begin
                    nxt_state = ST_DONE;
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                end else begin
                    nxt_timer = timer_q + TW'(1);
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
                nxt_last  = gnt_q;
                nxt_timer = '0;
            end
            default: nxt_state = ST_IDLE;
        endcase

        if (fin) begin
            nxt_err = fin_err;
            if (nxt_gnt == GNT_CPU) begin
                nxt_cpu_done  = 1'b1;
                nxt_cpu_rdata = fin_data;
            end else begin
                nxt_cready    = 1'b1;
                nxt_cli_rdata = fin_data;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= GNT_CPU;
            last_gnt_q    <= GNT_CLI;
            timer_q       <= '0;
            CpuDone       <= 1'b0;
            CpuRData      <= '0;
            ClientMemRead <= '0;
            CReady        <= 1'b0;
            Err           <= 1'b0;
            MemEn         <= 1'b0;
            MemWe         <= 1'b0;
            MemMode       <= SZ_NONE;
            MemAddr       <= '0;
            MemWData      <= '0;
        end else begin
            state_q       <= nxt_state;
            gnt_q         <= nxt_gnt;
            last_gnt_q    <= nxt_last;
            timer_q       <= nxt_timer;
            CpuDone       <= nxt_cpu_done;
            CpuRData      <= nxt_cpu_rdata;
            ClientMemRead <= nxt_cli_rdata;
            CReady        <= nxt_cready;
            Err           <= nxt_err;
            MemEn         <= nxt_mem_en;
            MemWe         <= nxt_mem_we;
            MemMode       <= nxt_mem_mode;
            MemAddr       <= nxt_mem_addr;
            MemWData      <= nxt_mem_wdata;
        end
    end

`ifdef MC_ARB_STATS_EN
    // Counters advance once per completed transaction, in the DONE cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            CpuGntCnt <= '0;
            CliGntCnt <= '0;
            ErrCnt    <= '0;
        end else if (state_q == ST_DONE) begin
            if (gnt_q == GNT_CPU) begin
                if (CpuGntCnt != '1) CpuGntCnt <= CpuGntCnt + 16'd1;
            end else begin
                if (CliGntCnt != '1) CliGntCnt <= CliGntCnt + 16'd1;
            end
            if (Err && (ErrCnt != '1)) ErrCnt <= ErrCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_dmem_arbiter.sv
// Directed bench for mc_dmem_arbiter: latency, round-robin, alignment, timeout, reset.
module tb_mc_dmem_arbiter;

    logic        Clk;
    logic        Rst;
    logic        CpuReq;
    logic        CpuWe;
    logic [1:0]  CpuMode;
    logic [31:0] CpuAddr;
    logic [31:0] CpuWData;
    logic        CpuDone;
    logic [31:0] CpuRData;
    logic [31:0] ClientMemAddr;
    logic [31:0] ClientMemWrite;
    logic [1:0]  CWDM;
    logic [1:0]  CRDM;
    logic [31:0] ClientMemRead;
    logic        CReady;
    logic        Err;
    logic        MemEn;
    logic        MemWe;
    logic [1:0]  MemMode;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;
`ifdef MC_ARB_STATS_EN
    logic [15:0] CpuGntCnt;
    logic [15:0] CliGntCnt;
    logic [15:0] ErrCnt;
`endif

    mc_dmem_arbiter #(.AW(32), .DW(32), .TO_CYC(16)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .CpuReq         (CpuReq),
        .CpuWe          (CpuWe),
        .CpuMode        (CpuMode),
        .CpuAddr        (CpuAddr),
        .CpuWData       (CpuWData),
        .CpuDone        (CpuDone),
        .CpuRData       (CpuRData),
        .ClientMemAddr  (ClientMemAddr),
        .ClientMemWrite (ClientMemWrite),
        .CWDM           (CWDM),
        .CRDM           (CRDM),
        .ClientMemRead  (ClientMemRead),
        .CReady         (CReady),
        .Err            (Err),
        .MemEn          (MemEn),
        .MemWe          (MemWe),
        .MemMode        (MemMode),
        .MemAddr        (MemAddr),
        .MemWData       (MemWData),
        .MemRData       (MemRData),
        .MemAck         (MemAck)
`ifdef MC_ARB_STATS_EN
        ,
        .CpuGntCnt      (CpuGntCnt),
        .CliGntCnt      (CliGntCnt),
        .ErrCnt         (ErrCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          checks;
    int          errors;
    int          resp_cnt;
    int          ack_dly;
    logic        ack_on;
    logic        force_ack;
    logic [31:0] resp_data;
    logic        any_act;

    int          r_lat;
    int          r_en_cnt;
    logic [31:0] r_en_addr;
    logic [31:0] r_en_wd;
    logic        r_en_we;
    logic [1:0]  r_en_mode;
    logic        r_cpu;
    logic        r_cli;
    logic        r_err;
    logic [31:0] r_crd;
    logic [31:0] r_lrd;
    int          n_cpu;
    int          n_cli;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One clock; sample #1 after the edge and play the memory side.
    task automatic step();
        @(posedge Clk);
        #1;
        MemAck = force_ack;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                MemAck   = 1'b1;
                MemRData = resp_data;
            end
        end
        if (MemEn && ack_on) resp_cnt = ack_dly;
    endtask

    task automatic run_txn(input int max_cyc);
        r_lat = 0; r_en_cnt = 0; r_en_addr = '0; r_en_wd = '0; r_en_we = 1'b0; r_en_mode = 2'b00;
        r_cpu = 1'b0; r_cli = 1'b0; r_err = 1'b0; r_crd = '0; r_lrd = '0;
        while ((r_lat < max_cyc) && !(r_cpu || r_cli)) begin
            step();
            r_lat++;
            if (MemEn) begin
                r_en_cnt++;
                r_en_addr = MemAddr;
                r_en_wd   = MemWData;
                r_en_we   = MemWe;
                r_en_mode = MemMode;
            end
            if (CpuDone || CReady) begin
                r_cpu = CpuDone;
                r_cli = CReady;
                r_err = Err;
                r_crd = CpuRData;
                r_lrd = ClientMemRead;
            end
        end
        if (!(r_cpu || r_cli)) chk("txn_done_in_bound", 32'(r_cpu | r_cli), 32'(1));
        if (r_cpu) n_cpu++;
        if (r_cli) n_cli++;
        if (r_err) n_err++;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        resp_cnt = 0;
        step();
        Rst = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        Rst = 1'b0;
        CpuReq = 1'b0; CpuWe = 1'b0; CpuMode = 2'b00; CpuAddr = '0; CpuWData = '0;
        ClientMemAddr = '0; ClientMemWrite = '0; CWDM = 2'b00; CRDM = 2'b00;
        MemRData = '0; MemAck = 1'b0;
        resp_cnt = 0; ack_dly = 1; ack_on = 1'b1; force_ack = 1'b0; resp_data = '0; any_act = 1'b0;
        n_cpu = 0; n_cli = 0; n_err = 0;

        repeat (2) step();
        chk("rst_pulses", 32'({CpuDone, CReady, Err, MemEn}), 32'(0));
        chk("rst_memaddr", MemAddr, 32'h0);
        chk("rst_rdata", CpuRData | ClientMemRead, 32'h0);
        Rst = 1'b1;
        step();

        // Single CPU word load, cycle-exact
        resp_data = 32'h1122_3344;
        CpuReq = 1'b1; CpuWe = 1'b0; CpuMode = 2'b11; CpuAddr = 32'h8000;
        step();
        chk("t1_memen_c1", 32'(MemEn), 32'(1));
        chk("t1_memaddr", MemAddr, 32'h8000);
        chk("t1_mode_we", 32'({MemMode, MemWe}), 32'(3'b110));
        step();
        chk("t1_c2_quiet", 32'({MemEn, CpuDone}), 32'(0));
        step();
        chk("t1_done_c3", 32'({CpuDone, CReady, Err}), 32'(3'b100));
        chk("t1_rdata", CpuRData, 32'h1122_3344);
        CpuReq = 1'b0;
        step();
        chk("t1_c4_done_low", 32'(CpuDone), 32'(0));

        // Tie after reset: CPU, then client, then CPU again
        do_reset();
        CpuReq = 1'b1; CpuMode = 2'b11; CpuAddr = 32'h100;
        CWDM = 2'b11; ClientMemAddr = 32'h200; ClientMemWrite = 32'hCAFE_F00D;
        run_txn(8);
        chk("t2a_cpu_first", 32'({r_cpu, r_cli}), 32'(2'b10));
        chk("t2a_addr", r_en_addr, 32'h100);
        chk("t2a_lat", 32'(r_lat), 32'(3));
        run_txn(8);
        chk("t2b_cli_second", 32'({r_cpu, r_cli}), 32'(2'b01));
        chk("t2b_addr", r_en_addr, 32'h200);
        chk("t2b_wdata", r_en_wd, 32'hCAFE_F00D);
        chk("t2b_lat", 32'(r_lat), 32'(4));
        run_txn(8);
        chk("t2c_cpu_third", 32'({r_cpu, r_cli}), 32'(2'b10));
        CpuReq = 1'b0; CWDM = 2'b00;
        step();

        // Misaligned client half write
        ClientMemAddr = 32'h8001; CWDM = 2'b10;
        run_txn(8);
        chk("t3_mis_cready_err", 32'({r_cli, r_err}), 32'(2'b11));
        chk("t3_mis_no_memen", 32'(r_en_cnt), 32'(0));
        chk("t3_mis_lat", 32'(r_lat), 32'(1));
        CWDM = 2'b00;
        step();

        // Write and read both set: write only
        CWDM = 2'b11; CRDM = 2'b01; ClientMemAddr = 32'h8004; ClientMemWrite = 32'hA5A5_A5A5;
        run_txn(8);
        chk("t3_wr_we_mode", 32'({r_en_we, r_en_mode}), 32'(3'b111));
        chk("t3_wr_data", r_en_wd, 32'hA5A5_A5A5);
        chk("t3_wr_cready", 32'({r_cli, r_err, r_en_cnt[1:0]}), 32'(4'b1001));
        CWDM = 2'b00; CRDM = 2'b00;
        step();

        // Client byte read, zero-extended
        resp_data = 32'hDEAD_BEEF;
        CRDM = 2'b01; ClientMemAddr = 32'h8003;
        run_txn(8);
        chk("rd_byte", r_lrd, 32'h0000_00EF);
        CRDM = 2'b00;
        step();

        // CPU misaligned word
        CpuReq = 1'b1; CpuMode = 2'b11; CpuAddr = 32'h8002;
        run_txn(8);
        chk("cpu_mis_err", 32'({r_cpu, r_err, r_en_cnt[1:0]}), 32'(4'b1100));
        CpuReq = 1'b0;
        step();

        // CPU half read, zero-extended
        resp_data = 32'h1234_5678;
        CpuReq = 1'b1; CpuMode = 2'b10; CpuAddr = 32'h2;
        run_txn(8);
        chk("rd_half", r_crd, 32'h0000_5678);
        chk("rd_half_noerr", 32'(r_err), 32'(0));
        CpuReq = 1'b0;
        step();

        // CpuReq with mode none is not a request
        CpuReq = 1'b1; CpuMode = 2'b00; any_act = 1'b0;
        repeat (4) begin
            step();
            any_act = any_act | MemEn | CpuDone | CReady;
        end
        chk("mode_none_idle", 32'(any_act), 32'(0));

        // Ack never comes: error completion 16 cycles after ISSUE
        ack_on = 1'b0;
        CpuMode = 2'b11; CpuAddr = 32'h40;
        run_txn(40);
        chk("to_done_err", 32'({r_cpu, r_err}), 32'(2'b11));
        chk("to_lat", 32'(r_lat), 32'(17));
        chk("to_rdata_zero", r_crd, 32'h0);
        chk("to_one_memen", 32'(r_en_cnt), 32'(1));
        CpuReq = 1'b0;
        ack_on = 1'b1; force_ack = 1'b1; resp_data = 32'h99; MemRData = 32'h99; any_act = 1'b0;
        repeat (4) begin
            step();
            any_act = any_act | MemEn | CpuDone | CReady;
        end
        force_ack = 1'b0;
        chk("late_ack_ignored", 32'(any_act), 32'(0));
        resp_data = 32'h5566_7788;
        CpuReq = 1'b1; CpuAddr = 32'h44;
        run_txn(8);
        chk("post_to_lat", 32'(r_lat), 32'(3));
        chk("post_to_rdata", r_crd, 32'h5566_7788);
        CpuReq = 1'b0;
        step();

        // Reset asserted while in WAIT
        ack_on = 1'b0;
        CpuReq = 1'b1; CpuAddr = 32'h80;
        step();
        step();
        CWDM = 2'b11; ClientMemAddr = 32'h300;
        Rst = 1'b0;
        #1;
        chk("t5_async_addr", MemAddr, 32'h0);
        chk("t5_async_pulses", 32'({MemEn, CpuDone, CReady, Err, MemMode}), 32'(0));
        any_act = 1'b0;
        step();
        any_act = any_act | MemEn | CpuDone | CReady | Err;
        Rst = 1'b1; ack_on = 1'b1; resp_cnt = 0;
        run_txn(8);
        chk("t5_cpu_wins", 32'({r_cpu, r_cli}), 32'(2'b10));
        chk("t5_cpu_addr", r_en_addr, 32'h80);
        chk("t5_no_spurious", 32'(any_act), 32'(0));
        CpuReq = 1'b0;
        run_txn(8);
        chk("t5_cli_next", r_en_addr, 32'h300);
        CWDM = 2'b00;
        step();

        // Mix for the statistics counters
        do_reset();
        n_cpu = 0; n_cli = 0; n_err = 0;
        for (int i = 0; i < 3; i++) begin
            CpuReq = 1'b1; CpuMode = 2'b11; CpuAddr = 32'(i * 4);
            run_txn(8);
            CpuReq = 1'b0;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            CRDM = 2'b11; ClientMemAddr = 32'h10 + 32'(i * 4);
            run_txn(8);
            CRDM = 2'b00;
            step();
        end
        CWDM = 2'b11; ClientMemAddr = 32'h11;
        run_txn(8);
        CWDM = 2'b00;
        step();
        chk("mix_cpu_done", 32'(n_cpu), 32'(3));
        chk("mix_cli_done", 32'(n_cli), 32'(3));
        chk("mix_err", 32'(n_err), 32'(1));
`ifdef MC_ARB_STATS_EN
        chk("stat_cpu", 32'(CpuGntCnt), 32'(3));
        chk("stat_cli", 32'(CliGntCnt), 32'(3));
        chk("stat_err", 32'(ErrCnt), 32'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
